// File: rtl/serial_image_loader_if.sv
// rtl/serial_image_loader_if.sv - byte input and image output bundle for serial_image_loader
//
// Purpose: groups the serial receiver byte handshake and the committed image
// outputs that feed the morphologic GA.
// Ports (interface members):
//   rxData        8        received byte, valid while rxFinish is high
//   rxFinish      1        one-cycle strobe per received byte
//   origin        W*H      committed origin image, row 0 in MSBs
//   objetive      W*H      committed objective image, row 0 in MSBs
//   originValid   1        sticky, set by first origin commit
//   objetiveValid 1        sticky, set by first objective commit
//   restart       1        one-cycle pulse on any commit
//   frameError    1        one-cycle pulse on checksum mismatch or timeout
//   busy          1        high while a frame is in progress
// Modports: master drives bytes (receiver side), slave is the loader.
interface serial_image_loader_if #(
  parameter int ImageWidth  = 8,
  parameter int ImageHeight = 4
);
  localparam int Pixels = ImageWidth * ImageHeight;

  logic [7:0]        rxData;
  logic              rxFinish;
  logic [Pixels-1:0] origin;
  logic [Pixels-1:0] objetive;
  logic              originValid;
  logic              objetiveValid;
  logic              restart;
  logic              frameError;
  logic              busy;

  modport master (
    output rxData, rxFinish,
    input  origin, objetive, originValid, objetiveValid, restart, frameError, busy
  );

  modport slave (
    input  rxData, rxFinish,
    output origin, objetive, originValid, objetiveValid, restart, frameError, busy
  );
endinterface

// File: rtl/serial_image_loader.sv
// rtl/serial_image_loader.sv - framed serial loader for the GA origin/objective images
//
// Purpose: decodes frames (header A0/A1, PayloadBytes data bytes, optional
// XOR checksum) from the serial receiver byte stream and commits them into
// the origin or objective image register, pulsing restart on each commit.
// Optional feature macro: IMAGE_LOADER_CHECKSUM_EN (frame carries a checksum
// byte checked in CHECK; when undefined, commit follows the last data byte).
// Ports:
//   clk  in   system clock, rising edge
//   rst  in   synchronous active-high reset
//   bus  slave modport of serial_image_loader_if (bytes in, images out)
module serial_image_loader #(
  parameter int ImageWidth   = 8,
  parameter int ImageHeight  = 4,
  parameter int TimeoutWidth = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  serial_image_loader_if.slave bus
);
  localparam int Pixels       = ImageWidth * ImageHeight;
  localparam int PayloadBytes = Pixels / 8;
  localparam int CntWidth     = $clog2(PayloadBytes + 1);
  localparam logic [CntWidth-1:0] LastIdx = CntWidth'(PayloadBytes - 1);
  localparam logic [7:0] HdrOrigin   = 8'hA0;
  localparam logic [7:0] HdrObjetive = 8'hA1;

  typedef enum logic [1:0] {IDLE, DATA, CHECK, COMMIT} state_t;

  state_t                  r_state;
  state_t                  w_next;
  logic                    r_target;          // 0: origin, 1: objective
  logic [Pixels-1:0]       r_shadow;
  logic [CntWidth-1:0]     r_cnt;
  logic [TimeoutWidth-1:0] r_tmo;
  logic [Pixels-1:0]       r_origin;
  logic [Pixels-1:0]       r_objetive;
  logic                    r_origin_valid;
  logic                    r_objetive_valid;
  logic                    r_frame_error;

  logic                    w_strobe;
  logic                    w_is_hdr;
  logic                    w_start;
  logic                    w_last_data;
  logic                    w_waiting;
  logic                    w_timeout;
  logic                    w_check_fail;
  logic                    w_commit_go;
  logic                    w_error;
  logic                    w_restart;
  logic                    w_busy;
  logic [Pixels-1:0]       w_shadow_shift;
  logic [Pixels-1:0]       w_commit_img;

  assign w_strobe       = bus.rxFinish;
  assign w_is_hdr       = (bus.rxData == HdrOrigin) || (bus.rxData == HdrObjetive);
  // COMMIT lasts one cycle but still accepts a header, exactly like IDLE.
  assign w_start        = w_strobe && w_is_hdr && (r_state == IDLE || r_state == COMMIT);
  assign w_last_data    = (r_cnt == LastIdx);
  assign w_waiting      = (r_state == DATA) || (r_state == CHECK);
  // A strobe in the saturating cycle wins over the timeout.
  assign w_timeout      = w_waiting && !w_strobe && (r_tmo == '1);
  assign w_shadow_shift = {r_shadow[Pixels-9:0], bus.rxData};

`ifdef IMAGE_LOADER_CHECKSUM_EN
  logic [7:0] r_acc;
  logic       w_ck_ok;

  assign w_ck_ok      = (bus.rxData == r_acc);
  assign w_check_fail = (r_state == CHECK) && w_strobe && !w_ck_ok;
  assign w_commit_go  = (r_state == CHECK) && w_strobe && w_ck_ok;
  assign w_commit_img = r_shadow;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc <= '0;
    end else if (w_start) begin
      r_acc <= bus.rxData;
    end else if (r_state == DATA && w_strobe) begin
      r_acc <= r_acc ^ bus.rxData;
    end
  end
`else
  assign w_check_fail = 1'b0;
  // Without a checksum the last data byte commits directly, so the image is
  // taken from the shift result rather than the not-yet-updated shadow.
  assign w_commit_go  = (r_state == DATA) && w_strobe && w_last_data;
  assign w_commit_img = w_shadow_shift;
`endif

  assign w_error = w_timeout || w_check_fail;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE, COMMIT: w_next = w_start ? DATA : IDLE;
      DATA: begin
        if (w_timeout) begin
          w_next = IDLE;
        end else if (w_strobe && w_last_data) begin
`ifdef IMAGE_LOADER_CHECKSUM_EN
          w_next = CHECK;
`else
          w_next = COMMIT;
`endif
        end
      end
      CHECK: begin
        if (w_timeout || w_check_fail) begin
          w_next = IDLE;
        end else if (w_commit_go) begin
          w_next = COMMIT;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    w_restart = 1'b0;
    w_busy    = 1'b0;
    if (r_state == COMMIT) begin
      w_restart = 1'b1;
    end
    if (r_state != IDLE) begin
      w_busy = 1'b1;
    end
  end

  // Frame datapath and committed images
  always_ff @(posedge clk) begin
    if (rst) begin
      r_target         <= 1'b0;
      r_shadow         <= '0;
      r_cnt            <= '0;
      r_tmo            <= '0;
      r_origin         <= '0;
      r_objetive       <= '0;
      r_origin_valid   <= 1'b0;
      r_objetive_valid <= 1'b0;
      r_frame_error    <= 1'b0;
    end else begin
      r_frame_error <= w_error;

      if (w_waiting && !w_strobe) begin
        r_tmo <= r_tmo + 1'b1;
      end else begin
        r_tmo <= '0;
      end

      if (w_start) begin
        r_target <= bus.rxData[0];
        r_cnt    <= '0;
        r_shadow <= '0;
      end else if (r_state == DATA && w_strobe) begin
        r_cnt    <= r_cnt + 1'b1;
        r_shadow <= w_shadow_shift;
      end else if (w_error) begin
        r_shadow <= '0;
      end

      if (w_commit_go) begin
        if (r_target) begin
          r_objetive       <= w_commit_img;
          r_objetive_valid <= 1'b1;
        end else begin
          r_origin         <= w_commit_img;
          r_origin_valid   <= 1'b1;
        end
      end
    end
  end

  assign bus.origin        = r_origin;
  assign bus.objetive      = r_objetive;
  assign bus.originValid   = r_origin_valid;
  assign bus.objetiveValid = r_objetive_valid;
  assign bus.restart       = w_restart;
  assign bus.frameError    = r_frame_error;
  assign bus.busy          = w_busy;
endmodule
